// File: rtl/riscv_soc_pkg.sv
// Shared RV_SoC definitions used by the instruction/data SRAM arbiter.
//   owner_t      : which requester owns the in-flight SRAM response
//   MAX_WAIT_DEF : default bound on consecutive denied fetch cycles
//   SRAM_LAT     : SRAM read latency in cycles; the arbiter's response
//                  tracking is one register deep and relies on this being 1
package riscv_soc_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int MAX_WAIT_DEF = 4;
    localparam int SRAM_LAT     = 1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM port of mem_arbiter.
//   slave  : arbiter view (takes requests and SRAM read data, drives
//            grants, responses and the SRAM command)
//   master : environment view (core ports plus the SRAM macro)
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // fetch port
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    // data port
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    // SRAM port
    logic          m_en;
    logic          m_we;
    logic [3:0]    m_be;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_lock, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output m_en, m_we, m_be, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_lock, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  m_en, m_we, m_be, m_addr, m_wdata,
        output m_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous SRAM between the instruction-fetch
// port and the data port of the core. One grant per cycle, data first,
// except that fetch is forced through after MAX_WAIT consecutive denials,
// and a locked data read reserves the following grant slot for data.
// Read data comes back one cycle after the grant, steered by resp_own.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-low
//   bus  : mem_arbiter_if.slave (fetch, data and SRAM signals)
//   busy : a response is pending or the data lock is held
module mem_arbiter
    import riscv_soc_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    mem_arbiter_if.slave       bus,
    output logic               busy
);

    localparam logic [3:0] MAXW = 4'(MAX_WAIT);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_wait
        $error("mem_arbiter: MAX_WAIT must be 1..15");
    end
    if (SRAM_LAT != 1) begin : g_bad_lat
        $error("mem_arbiter: response tracking assumes SRAM_LAT == 1");
    end

    logic [3:0] starve_cnt;
    logic       lock_hold;
    owner_t     resp_own;
    logic       i_gnt;
    logic       d_gnt;

    // Byte offset of the data address is dropped; the requester traps
    // misaligned accesses before they get here.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.d_addr[1:0];

    // Grant priority: lock, starvation override, data, fetch.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (rst) begin
            if (lock_hold)
                d_gnt = bus.d_req;       // fetch stays out even if data is idle
            else if (starve_cnt == MAXW && bus.i_req)
                i_gnt = 1'b1;
            else if (bus.d_req)
                d_gnt = 1'b1;
            else if (bus.i_req)
                i_gnt = 1'b1;
        end
    end

    // SRAM command mux; everything idles at zero when nobody is granted.
    always_comb begin
        bus.m_we    = 1'b0;
        bus.m_be    = 4'h0;
        bus.m_addr  = {AW{1'b0}};
        bus.m_wdata = {DW{1'b0}};
        if (d_gnt) begin
            bus.m_we    = bus.d_we;
            bus.m_be    = bus.d_we ? bus.d_be : 4'hF;
            bus.m_addr  = {2'b00, bus.d_addr[AW-1:2]};
            bus.m_wdata = bus.d_wdata;
        end else if (i_gnt) begin
            bus.m_be    = 4'hF;
            bus.m_addr  = bus.i_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
            lock_hold  <= 1'b0;
            resp_own   <= OWN_NONE;
        end else begin
            if (i_gnt)
                starve_cnt <= 4'd0;
            else if (bus.i_req && starve_cnt != MAXW)
                starve_cnt <= starve_cnt + 4'd1;

            // Any data grant ends the lock; only a locked read starts one.
            if (d_gnt)
                lock_hold <= !bus.d_we && bus.d_lock;

            resp_own <= d_gnt ? OWN_D : (i_gnt ? OWN_I : OWN_NONE);
        end
    end

    assign bus.i_gnt    = i_gnt;
    assign bus.d_gnt    = d_gnt;
    assign bus.m_en     = i_gnt | d_gnt;
    assign bus.i_rvalid = (resp_own == OWN_I);
    assign bus.d_rvalid = (resp_own == OWN_D);
    assign bus.i_rdata  = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;
    assign busy         = (resp_own != OWN_NONE) | lock_hold;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed per-cycle grant checks and
// a scoreboard of expected responses, popped one cycle after each grant.
module tb_mem_arbiter;
    import riscv_soc_pkg::*;

    typedef struct {
        owner_t      own;
        logic [31:0] data;
        logic        dchk;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    // SRAM model: one-cycle read latency, contents derived from address.
    always @(posedge clk)
        if (bus.m_en && !bus.m_we) bus.m_rdata <= pat(bus.m_addr);

    function automatic exp_t mk(input owner_t o, input logic [31:0] d, input logic c);
        exp_t e;
        e.own = o; e.data = d; e.dchk = c;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [3:0] be, input logic dl, input logic [31:0] da,
                         input logic [31:0] dwd);
        bus.i_req = ir; bus.i_addr = ia;
        bus.d_req = dr; bus.d_we = dw; bus.d_be = be; bus.d_lock = dl;
        bus.d_addr = da; bus.d_wdata = dwd;
    endtask

    // Checks the current cycle (called at negedge) and queues the response
    // expected next cycle.
    task automatic check_cyc(input logic eig, input logic edg, input logic [31:0] ea,
                             input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd,
                             input logic eb);
        exp_t e;
        chk("i_gnt", 32'(bus.i_gnt), 32'(eig));
        chk("d_gnt", 32'(bus.d_gnt), 32'(edg));
        chk("m_en", 32'(bus.m_en), 32'(eig | edg));
        if (eig || edg) begin
            chk("m_addr", bus.m_addr, ea);
            chk("m_we", 32'(bus.m_we), 32'(ewe));
            chk("m_be", 32'(bus.m_be), 32'(ebe));
            chk("m_wdata", bus.m_wdata, ewd);
        end
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("i_rvalid", 32'(bus.i_rvalid), 32'(e.own == OWN_I));
            chk("d_rvalid", 32'(bus.d_rvalid), 32'(e.own == OWN_D));
            if (e.own == OWN_I) chk("i_rdata", bus.i_rdata, e.data);
            if (e.own == OWN_D && e.dchk) chk("d_rdata", bus.d_rdata, e.data);
        end
        chk("busy", 32'(busy), 32'(eb));
        if (eig)      sb.push_back(mk(OWN_I, pat(ea), 1'b1));
        else if (edg) sb.push_back(mk(OWN_D, pat(ea), !ewe));
        else          sb.push_back(mk(OWN_NONE, 32'd0, 1'b0));
    endtask

    task automatic step(input logic eig, input logic edg, input logic [31:0] ea,
                        input logic ewe, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic eb);
        @(negedge clk);
        check_cyc(eig, edg, ea, ewe, ebe, ewd, eb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset with both requests asserted: nothing may be granted
        rst = 1'b0;
        drive(1, 32'h1000, 1, 0, 4'hF, 0, 32'h2000, 0);
        sb.push_back(mk(OWN_NONE, 32'd0, 1'b0));
        @(posedge clk); #1;
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        rst = 1'b1;
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // fetch only
        drive(1, 32'h8000_0000, 0, 0, 4'h0, 0, 0, 0);
        step(1, 0, 32'h8000_0000, 0, 4'hF, 0, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // data read, byte address 0x108 -> word 0x42
        drive(0, 0, 1, 0, 4'h3, 0, 32'h108, 32'h1234);
        step(0, 1, 32'h42, 0, 4'hF, 32'h1234, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // data write: byte enables pass through, ack on d_rvalid
        drive(0, 0, 1, 1, 4'h3, 0, 32'h20, 32'hDEAD_BEEF);
        step(0, 1, 32'h8, 1, 4'h3, 32'hDEAD_BEEF, 0);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        // both held: D,D,D,D,I,D,D,D,D,I
        drive(1, 32'h100, 1, 0, 4'hF, 0, 32'h200, 0);
        for (int k = 0; k < 10; k++)
            step((k == 4 || k == 9), !(k == 4 || k == 9),
                 (k == 4 || k == 9) ? 32'h100 : 32'h80, 0, 4'hF, 0, (k != 0));
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // locked read, fetch shut out even once its starvation bound is hit
        drive(1, 32'h5000, 1, 0, 4'hF, 1, 32'h10, 0);
        step(0, 1, 32'h4, 0, 4'hF, 0, 0);
        drive(1, 32'h5000, 0, 0, 4'hF, 0, 32'h10, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        // locked write completes the sequence and must not re-arm the lock
        drive(1, 32'h5000, 1, 1, 4'b0100, 1, 32'h14, 32'h00AB_0000);
        step(0, 1, 32'h5, 1, 4'b0100, 32'h00AB_0000, 1);
        drive(1, 32'h5000, 0, 0, 4'h0, 0, 0, 0);
        step(1, 0, 32'h5000, 0, 4'hF, 0, 1);
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0);

        // reset right behind a fetch grant drops its response
        drive(1, 32'h3000, 0, 0, 4'h0, 0, 0, 0);
        @(negedge clk);
        check_cyc(1, 0, 32'h3000, 0, 4'hF, 0, 0);
        rst = 1'b0;
        void'(sb.pop_back());
        sb.push_back(mk(OWN_NONE, 32'd0, 1'b0));
        drive(1, 32'h3000, 1, 0, 4'hF, 0, 32'h400, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_cyc(0, 0, 0, 0, 0, 0, 0);
        chk("rst_m_addr", bus.m_addr, 32'd0);
        chk("rst_m_we", 32'(bus.m_we), 32'd0);
        chk("rst_m_be", 32'(bus.m_be), 32'd0);
        chk("rst_m_wdata", bus.m_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++)
            step((k == 4), (k != 4), (k == 4) ? 32'h3000 : 32'h100, 0, 4'hF, 0, (k != 0));
        drive(0, 0, 0, 0, 4'h0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
